// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: RV32 access sizes,
// FSM states and the latched request record.
package mem_pkg;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_lane_align.sv
// Per-access lane logic: byte enables, store replication, load extraction
// with sign/zero extension, and size/alignment legality.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  size_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);
  logic [31:0] rsh;

  // Selected lane lands in the low bits; for a legal word access addr is 0.
  assign rsh = rword_i >> {addr_i, 3'b000};

  always_comb begin
    be_o    = '0;
    wword_o = '0;
    rdata_o = '0;
    bad_o   = 1'b0;
    case (size_i)
      SZ_B, SZ_BU: begin
        be_o    = 4'b0001 << addr_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = (size_i == SZ_B) ? {{24{rsh[7]}}, rsh[7:0]} : {24'h0, rsh[7:0]};
        bad_o   = we_i && (size_i == SZ_BU);
      end
      SZ_H, SZ_HU: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = (size_i == SZ_H) ? {{16{rsh[15]}}, rsh[15:0]} : {16'h0, rsh[15:0]};
        bad_o   = addr_i[0] || (we_i && (size_i == SZ_HU));
      end
      SZ_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rsh;
        bad_o   = (addr_i != 2'b00);
      end
      default: bad_o = 1'b1;
    endcase
    if (bad_o) begin
      be_o    = '0;
      rdata_o = '0;
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory interface: one outstanding access,
// LATENCY wait states, registered response under valid/ready.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_e        state_q;
  req_t          req_q;
  req_t          req_in;
  req_t          acc;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rdata_ext;
  logic          bad;
  logic          err_c;
  logic [31:0]   rdata_c;
  logic          commit;

  assign req_in = '{we: req_we, addr: req_addr, size: req_size, wdata: req_wdata};

  // With zero wait states the access commits in the accept cycle, straight
  // from the request inputs; otherwise it uses the latched copy.
  assign acc      = (state_q == ST_IDLE) ? req_in : req_q;
  assign idx      = acc.addr[AW+1:2];
  assign in_range = ({2'b00, acc.addr[31:2]} < 32'(DEPTH_WORDS));
  assign rword    = mem[idx];

  mem_lane_align u_align (
    .addr_i  (acc.addr[1:0]),
    .size_i  (acc.size),
    .we_i    (acc.we),
    .wdata_i (acc.wdata),
    .rword_i (rword),
    .be_o    (be),
    .wword_o (wword),
    .rdata_o (rdata_ext),
    .bad_o   (bad)
  );

  assign err_c   = bad || !in_range;
  assign rdata_c = (err_c || acc.we) ? 32'h0 : rdata_ext;
  assign commit  = ((state_q == ST_IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == '0));

  always_ff @(posedge clk) begin
    if (!reset && commit && acc.we && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_q       <= req_in;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_c;
              rsp_err_q   <= err_c;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_c;
            rsp_err_q   <= err_c;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench: byte-array reference model checked every cycle against a
// LATENCY=2 responder, plus directed literals and a LATENCY=0 instance.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_size;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [2:0]  b_req_size;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_at_edge = 1'b1;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_size(b_req_size), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Reference memory as a flat byte array.
  logic [7:0] mdl [0:4*DEPTH-1];

  function automatic void model_eval(input logic we, input logic [31:0] a, input logic [2:0] sz,
                                     output logic er, output logic [31:0] rd, output int n);
    bit sgn;
    logic [31:0] v;
    n = 0; sgn = 0;
    case (sz)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: n = 0;
    endcase
    er = (n == 0) || (we && !sgn && n < 4) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    if (n != 0 && (a % n) != 0) er = 1'b1;
    rd = 32'h0;
    if (!er && !we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | ({24'h0, mdl[int'(a) + i]} << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  // Scoreboard state for the single outstanding access.
  bit          pend = 0, have_cur = 0, prev_v = 0, prev_rr = 0;
  int          acc_cyc, p_n;
  logic        p_we, cur_err;
  logic [31:0] p_addr, p_wd, cur_rd;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  always @(negedge clk) begin
    if (reset) begin
      pend = 0; have_cur = 0; prev_v = 0; prev_rr = 0;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      if (rst_at_edge) begin
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      end
    end else begin
      if (prev_v && !prev_rr && !rsp_valid) fail("rsp_valid_dropped");
      if (rsp_valid) begin
        chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
        if (!prev_v) begin
          if (!pend) fail("spurious_rsp");
          else begin
            chk("latency", cyc - acc_cyc, LAT + 1);
            if (p_we && !cur_err)
              for (int i = 0; i < p_n; i++) mdl[int'(p_addr) + i] = p_wd[8*i +: 8];
            pend = 0;
            have_cur = 1;
          end
        end else if (prev_rr) fail("rsp_after_handshake");
        if (have_cur) begin
          chk("rsp_rdata", rsp_rdata, cur_rd);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, cur_err});
        end
      end
      if (req_valid && req_ready) begin
        if (pend) fail("accept_while_busy");
        model_eval(req_we, req_addr, req_size, cur_err, cur_rd, p_n);
        p_we = req_we; p_addr = req_addr; p_wd = req_wdata;
        pend = 1; have_cur = 0; acc_cyc = cyc;
      end
      prev_v  = rsp_valid;
      prev_rr = rsp_ready;
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bit ok = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      @(posedge clk); #1;
    end
    // Scramble the inputs after accept: the latched copy must be used.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_size = 3'($urandom); req_wdata = $urandom;
    if (!ok) fail("accept_timeout");
  endtask

  task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic er);
    bit ok = 0;
    rsp_ready = (hold == 0);
    rd = 32'hx; er = 1'bx;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    if (!ok) begin
      fail("rsp_timeout");
      rsp_ready = 1'b1;
      return;
    end
    rd = rsp_rdata; er = rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      req_valid = (k == 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic er);
    issue(we, a, sz, wd);
    wait_rsp(hold, rd, er);
  endtask

  task automatic lit(input string nm, input logic [31:0] rd, input logic er,
                     input logic [31:0] exp_rd, input logic exp_er);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, {31'h0, er}, {31'h0, exp_er});
  endtask

  task automatic b_txn(input string nm, input logic we, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = a; b_req_size = sz; b_req_wdata = wd;
    @(negedge clk);
    chk({nm, "_ready"}, {31'h0, b_req_ready}, 32'h1);
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_req_addr = $urandom; b_req_wdata = $urandom;
    @(negedge clk);
    chk({nm, "_valid_t1"}, {31'h0, b_rsp_valid}, 32'h1);
    chk({nm, "_rdata"}, b_rsp_rdata, exp_rd);
    chk({nm, "_err"}, {31'h0, b_rsp_err}, {31'h0, exp_er});
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [2:0]  sz;
    int          r;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_size = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) txn(1'b1, 32'(4 * w), 3'b010, $urandom, 0, rd, er);

    txn(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, rd, er); lit("sw10", rd, er, 32'h0, 1'b0);
    txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);        lit("lw10", rd, er, 32'hDEADBEEF, 1'b0);
    txn(1'b1, 32'h11, 3'b000, 32'h000000A5, 0, rd, er);
    txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);        lit("lw10_sb", rd, er, 32'hDEADA5EF, 1'b0);
    txn(1'b0, 32'h11, 3'b000, 32'h0, 0, rd, er);        lit("lb11", rd, er, 32'hFFFFFFA5, 1'b0);
    txn(1'b0, 32'h11, 3'b100, 32'h0, 0, rd, er);        lit("lbu11", rd, er, 32'h000000A5, 1'b0);
    txn(1'b0, 32'h12, 3'b001, 32'h0, 0, rd, er);        lit("lh12", rd, er, 32'hFFFFDEAD, 1'b0);
    txn(1'b0, 32'h13, 3'b001, 32'h0, 0, rd, er);        lit("lh13_mis", rd, er, 32'h0, 1'b1);
    txn(1'b1, 32'h20, 3'b010, 32'h5A5A5A5A, 0, rd, er);
    txn(1'b1, 32'h22, 3'b010, 32'h11111111, 0, rd, er); lit("sw22_mis", rd, er, 32'h0, 1'b1);
    txn(1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er);        lit("lw20_kept", rd, er, 32'h5A5A5A5A, 1'b0);
    txn(1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, 0, rd, er); lit("sz011", rd, er, 32'h0, 1'b1);
    txn(1'b1, 32'h11, 3'b100, 32'hFFFFFFFF, 0, rd, er); lit("sbu_illegal", rd, er, 32'h0, 1'b1);
    txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);        lit("lw10_kept", rd, er, 32'hDEADA5EF, 1'b0);
    txn(1'b0, 32'(4 * DEPTH), 3'b010, 32'h0, 0, rd, er); lit("lw_range", rd, er, 32'h0, 1'b1);

    txn(1'b0, 32'h10, 3'b010, 32'h0, 5, rd, er);        lit("bp_lw10", rd, er, 32'hDEADA5EF, 1'b0);

    txn(1'b1, 32'h40, 3'b010, 32'h0BADF00D, 0, rd, er);
    issue(1'b1, 32'h40, 3'b010, 32'h12345678);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    txn(1'b0, 32'h40, 3'b010, 32'h0, 0, rd, er);        lit("lw40_after_rst", rd, er, 32'h0BADF00D, 1'b0);

    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 7));
      a  = (r == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
      if (r < 7) begin
        if (sz[1:0] == 2'b01) a[0] = 1'b0;
        if (sz[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      txn(1'($urandom_range(0, 1)), a, sz, $urandom, $urandom_range(0, 2), rd, er);
    end

    b_txn("l0_sw8", 1'b1, 32'h8, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
    b_txn("l0_lw8", 1'b0, 32'h8, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);
    b_txn("l0_lb9", 1'b0, 32'h9, 3'b000, 32'h0, 32'hFFFFFFF0, 1'b0);
    b_txn("l0_lhu", 1'b0, 32'hA, 3'b101, 32'h0, 32'h0000CAFE, 1'b0);
    b_txn("l0_mis", 1'b0, 32'h9, 3'b010, 32'h0, 32'h0, 1'b1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface: accepts one load/store request at a time, models configurable wait states, and returns a response under a valid/ready handshake.
- Sits between the multicycle core's load/store path and a word-organised on-chip RAM.
- Handles byte/halfword/word lane selection, sign/zero extension for loads, and byte-enable merging for stores.
- Flags misaligned, out-of-range and illegal-size accesses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the internal array; byte address range 0..4*DEPTH_WORDS-1
LATENCY, 2, wait cycles between request acceptance and access commit; 0 is legal

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  3  RV32 funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_wdata  in  32  store data, right-aligned (bits [7:0] for B, [15:0] for H)
rsp_valid  out  1  response present
rsp_ready  in  1  initiator accepts response
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  out  1  access rejected

Behaviour:
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0.
  - WAIT: req_ready=0, wait-state countdown.
  - RESP: rsp_valid=1, req_ready=0.
- Handshake:
  - Accept occurs when req_valid && req_ready.
  - On accept, latch we, addr, size and wdata. Later changes on req_* have no effect.
- Transitions:
  - IDLE->WAIT on accept if LATENCY>0; counter loaded with LATENCY-1.
  - IDLE->RESP on accept if LATENCY==0.
  - WAIT decrements the counter each cycle. At 0 it commits the access and moves to RESP.
  - RESP->IDLE when rsp_ready=1. No new accept in that same cycle; next accept is possible one cycle later.
- Latency:
  - Accept at cycle t gives rsp_valid at t+LATENCY+1.
  - rsp_rdata and rsp_err are registered and stable while rsp_valid=1.
- Commit:
  - The array read/write happens exactly once, on entry to RESP.
  - Stores with rsp_err=1 do not modify the array.
- Error conditions (rsp_err=1, rsp_rdata=0):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - size in {011, 110, 111}, or store with size BU/HU.
  - addr[31:2] >= DEPTH_WORDS.
- Load extraction:
  - The byte or halfword is selected by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W is passed through.
- Store merge:
  - The byte/halfword is replicated to its lane via addr[1:0].
  - Byte-enable masks the write: B = one lane, H = lanes {0,1} or {2,3}, W = all. Other bytes of the word are preserved.
- Reset:
  - Next state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - req_ready=0 while reset is high.
  - Array contents are not reset.
- Reset mid-operation (WAIT or RESP): the transaction is abandoned, an uncommitted store is discarded, and no response is issued.
- rsp_valid held with rsp_ready=0: the responder stays in RESP indefinitely and its outputs remain unchanged.

Decomposition:
- Package mem_pkg holds:
  - size constants SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101;
  - state encoding ST_IDLE, ST_WAIT, ST_RESP.
- One combinational sub-module, mem_lane_align, owns the per-access lane logic:
  - inputs: addr[1:0], size, wdata, raw read word;
  - outputs: 4-bit byte-enable, lane-shifted write word, extended load result, misalign/illegal flag.
- The top level owns the FSM, counter, range check and array.

Test Plan:
- Word store then load, LATENCY=2:
  - SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
  - Required: rdata 0xDEADBEEF, err=0, rsp_valid exactly 3 cycles after each accept.
- Byte lanes on word 0x10 = 0xDEADBEEF:
  - SB 0x11 data 0x000000A5, then LW 0x10 -> 0xDEADA5EF.
  - LB 0x11 -> 0xFFFFFFA5.
  - LBU 0x11 -> 0x000000A5.
  - LH 0x12 -> 0xFFFFDEAD.
- Errors:
  - LH 0x13, SW 0x22 and size 011 each give err=1, rdata=0.
  - A following LW of a store's target word shows the word unchanged.
  - LW at byte address 4*DEPTH_WORDS -> err=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles.
  - Required: rsp_valid, rdata and err stable; req_ready=0 throughout; a req_valid pulse during RESP is ignored.
- Reset mid-operation:
  - Issue SW 0x40 data 0x12345678, assert reset during WAIT.
  - Required: no response issued; a later LW 0x40 returns the prior contents.
  - LATENCY=0 build: rsp_valid at t+1.
